// File: rtl/id_hazard_scheduler.sv
// ID-stage issue controller: load-use scoreboard, stall generation and
// branch/jump flush sequencing, plus a saturating stall-cycle counter.
module id_hazard_scheduler #(
    parameter int unsigned LOAD_LAT     = 1,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [4:0]           id_rs1_addr,
    input  logic [4:0]           id_rs2_addr,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic [4:0]           id_rd_addr,
    input  logic                 id_is_load,
    input  logic                 exe_branch_taken,
    output logic                 pc_stall,
    output logic                 ifid_stall,
    output logic                 idex_bubble,
    output logic                 ifid_flush,
    output logic                 issue,
    output logic [31:0]          busy_mask,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam logic [2:0] LoadLat     = 3'(LOAD_LAT);
    localparam logic [2:0] FlushReload = 3'(FLUSH_CYCLES - 1);
    localparam bit         MultiFlush  = (FLUSH_CYCLES > 1);
    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    state_e               state_q;
    logic [2:0]           flush_cnt_q;
    logic [2:0]           sb_cnt_q [32];
    logic [2:0]           sb_cnt_d [32];
    logic [CNT_WIDTH-1:0] stall_count_q;

    logic rs1_busy;
    logic rs2_busy;
    logic hz;
    logic flush_now;
    logic stall_evt;
    logic sb_set;

    // Pending mask: a register is busy while its countdown is nonzero; x0 never is.
    always_comb begin
        busy_mask = '0;
        for (int i = 1; i < 32; i++) begin
            busy_mask[i] = (sb_cnt_q[i] != 3'd0);
        end
    end

    // Load-use hazard on either used, nonzero source register.
    always_comb begin
        rs1_busy = id_rs1_used && (id_rs1_addr != 5'd0) && busy_mask[id_rs1_addr];
        rs2_busy = id_rs2_used && (id_rs2_addr != 5'd0) && busy_mask[id_rs2_addr];
        hz       = id_valid && (rs1_busy || rs2_busy);
    end

    // Pipeline controls; flush outranks stall, everything is quiet under reset.
    always_comb begin
        flush_now   = 1'b0;
        stall_evt   = 1'b0;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        issue       = 1'b0;
        if (!rst) begin
            if (state_q == StFlush || exe_branch_taken) begin
                flush_now   = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (hz) begin
                stall_evt   = 1'b1;
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
            end else begin
                issue = id_valid;
            end
        end
    end

    // Only an instruction that actually issues may claim its destination.
    assign sb_set = issue && id_is_load && (id_rd_addr != 5'd0);

    // Scoreboard next state: a new load overrides the per-cycle countdown.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            if (sb_set && (id_rd_addr == 5'(i))) begin
                sb_cnt_d[i] = LoadLat;
            end else if (sb_cnt_q[i] != 3'd0) begin
                sb_cnt_d[i] = sb_cnt_q[i] - 3'd1;
            end else begin
                sb_cnt_d[i] = 3'd0;
            end
        end
    end

    // Scoreboard countdown registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                sb_cnt_q[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                sb_cnt_q[i] <= sb_cnt_d[i];
            end
        end
    end

    // Run/flush sequencer and saturating stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StRun;
            flush_cnt_q   <= 3'd0;
            stall_count_q <= '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (exe_branch_taken) begin
                        flush_cnt_q <= FlushReload;
                        state_q     <= MultiFlush ? StFlush : StRun;
                    end else if (stall_evt && (stall_count_q != CntMax)) begin
                        stall_count_q <= stall_count_q + CNT_WIDTH'(1);
                    end
                end
                StFlush: begin
                    if (exe_branch_taken) begin
                        // A new taken branch restarts the squash window.
                        flush_cnt_q <= FlushReload;
                    end else if (flush_cnt_q <= 3'd1) begin
                        flush_cnt_q <= 3'd0;
                        state_q     <= StRun;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q     <= StRun;
                    flush_cnt_q <= 3'd0;
                end
            endcase
        end
    end

    assign stall_count = stall_count_q;

    // flush_now mirrors ifid_flush; kept as a named intent signal for readability.
    logic unused_flush_now;
    assign unused_flush_now = flush_now;

endmodule

// File: tb/tb_id_hazard_scheduler.sv
// Randomised scoreboard bench for id_hazard_scheduler with three parameter sets.
module tb_id_hazard_scheduler;

    typedef struct packed {
        logic        pc_stall;
        logic        ifid_stall;
        logic        idex_bubble;
        logic        ifid_flush;
        logic        issue;
        logic [31:0] busy;
        logic [31:0] scnt;
    } obs_t;

    typedef struct packed {
        logic [1:0] k;
        obs_t       o;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic id_valid = 1'b0;
    logic [4:0] id_rs1_addr = '0;
    logic [4:0] id_rs2_addr = '0;
    logic id_rs1_used = 1'b0;
    logic id_rs2_used = 1'b0;
    logic [4:0] id_rd_addr = '0;
    logic id_is_load = 1'b0;
    logic exe_branch_taken = 1'b0;

    logic        pcs [3];
    logic        ifs [3];
    logic        bub [3];
    logic        fls [3];
    logic        iss [3];
    logic [31:0] bm  [3];
    logic [3:0]  sc_a;
    logic [31:0] sc_b;
    logic [7:0]  sc_c;
    obs_t        act [3];

    // Reference model state, per DUT instance.
    int              pend  [3][32];
    int              fleft [3];
    longint unsigned scnt  [3];
    int              lat   [3] = '{1, 3, 2};
    int              fcy   [3] = '{2, 3, 1};
    longint unsigned cmax  [3] = '{64'd15, 64'hffff_ffff, 64'd255};

    ent_t expq [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    id_hazard_scheduler #(.LOAD_LAT(1), .FLUSH_CYCLES(2), .CNT_WIDTH(4)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1_addr(id_rs1_addr),
        .id_rs2_addr(id_rs2_addr), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd_addr(id_rd_addr), .id_is_load(id_is_load), .exe_branch_taken(exe_branch_taken),
        .pc_stall(pcs[0]), .ifid_stall(ifs[0]), .idex_bubble(bub[0]), .ifid_flush(fls[0]),
        .issue(iss[0]), .busy_mask(bm[0]), .stall_count(sc_a)
    );

    id_hazard_scheduler #(.LOAD_LAT(3), .FLUSH_CYCLES(3), .CNT_WIDTH(32)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1_addr(id_rs1_addr),
        .id_rs2_addr(id_rs2_addr), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd_addr(id_rd_addr), .id_is_load(id_is_load), .exe_branch_taken(exe_branch_taken),
        .pc_stall(pcs[1]), .ifid_stall(ifs[1]), .idex_bubble(bub[1]), .ifid_flush(fls[1]),
        .issue(iss[1]), .busy_mask(bm[1]), .stall_count(sc_b)
    );

    id_hazard_scheduler #(.LOAD_LAT(2), .FLUSH_CYCLES(1), .CNT_WIDTH(8)) dut_c (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1_addr(id_rs1_addr),
        .id_rs2_addr(id_rs2_addr), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd_addr(id_rd_addr), .id_is_load(id_is_load), .exe_branch_taken(exe_branch_taken),
        .pc_stall(pcs[2]), .ifid_stall(ifs[2]), .idex_bubble(bub[2]), .ifid_flush(fls[2]),
        .issue(iss[2]), .busy_mask(bm[2]), .stall_count(sc_c)
    );

    assign act[0] = {pcs[0], ifs[0], bub[0], fls[0], iss[0], bm[0], 32'(sc_a)};
    assign act[1] = {pcs[1], ifs[1], bub[1], fls[1], iss[1], bm[1], sc_b};
    assign act[2] = {pcs[2], ifs[2], bub[2], fls[2], iss[2], bm[2], 32'(sc_c)};

    task automatic check(input string name, input int k, input obs_t got, input obs_t exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s dut%0d t=%0t: got ps=%b is=%b bb=%b fl=%b iss=%b busy=%h cnt=%0d, expected ps=%b is=%b bb=%b fl=%b iss=%b busy=%h cnt=%0d",
                     name, k, $time, got.pc_stall, got.ifid_stall, got.idex_bubble,
                     got.ifid_flush, got.issue, got.busy, got.scnt, exp.pc_stall,
                     exp.ifid_stall, exp.idex_bubble, exp.ifid_flush, exp.issue, exp.busy,
                     exp.scnt);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 32; r++) pend[k][r] = 0;
            fleft[k] = 0;
            scnt[k]  = 0;
        end
    endtask

    // Predict this cycle's outputs from the current inputs, then advance one clock.
    task automatic model_step(input int k, output obs_t e);
        bit flush, hz, b1, b2;
        e = '0;
        for (int r = 0; r < 32; r++) e.busy[r] = (pend[k][r] != 0);
        flush = exe_branch_taken || (fleft[k] > 0);
        b1 = id_rs1_used && (id_rs1_addr != 0) && (pend[k][id_rs1_addr] != 0);
        b2 = id_rs2_used && (id_rs2_addr != 0) && (pend[k][id_rs2_addr] != 0);
        hz = id_valid && (b1 || b2);
        e.scnt        = 32'(scnt[k]);
        e.ifid_flush  = flush;
        e.idex_bubble = flush || hz;
        e.pc_stall    = !flush && hz;
        e.ifid_stall  = !flush && hz;
        e.issue       = !flush && !hz && id_valid;
        if (exe_branch_taken) fleft[k] = fcy[k] - 1;
        else if (fleft[k] > 0) fleft[k]--;
        if (e.pc_stall && scnt[k] < cmax[k]) scnt[k]++;
        for (int r = 0; r < 32; r++) if (pend[k][r] > 0) pend[k][r]--;
        if (e.issue && id_is_load && id_rd_addr != 0) pend[k][id_rd_addr] = lat[k];
    endtask

    task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic ld, input logic br);
        obs_t e;
        ent_t ent;
        @(negedge clk);
        id_valid = v; id_rs1_addr = r1; id_rs2_addr = r2; id_rs1_used = u1;
        id_rs2_used = u2; id_rd_addr = rd; id_is_load = ld; exe_branch_taken = br;
        for (int k = 0; k < 3; k++) begin
            model_step(k, e);
            ent.k = 2'(k);
            ent.o = e;
            expq.push_back(ent);
        end
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Assert reset mid-cycle, with a valid instruction present, and check quiet outputs.
    task automatic async_reset();
        #5;
        id_valid = 1'b1; exe_branch_taken = 1'b0;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) check("async_reset", k, act[k], obs_t'('0));
        @(posedge clk);
        @(negedge clk);
        id_valid = 1'b0; id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_is_load = 1'b0;
        exe_branch_taken = 1'b0;
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: compare every queued prediction once outputs have settled.
    initial begin
        ent_t ent;
        forever begin
            @(negedge clk);
            #2;
            while (expq.size() > 0) begin
                ent = expq.pop_front();
                check("cycle", int'(ent.k), act[ent.k], ent.o);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        id_valid = 1'b1;
        #3;
        for (int k = 0; k < 3; k++) check("power_on_reset", k, act[k], obs_t'('0));
        @(negedge clk);
        id_valid = 1'b0;
        rst = 1'b0;

        // Load x5 followed by a dependent read of x5.
        drive(1, 0, 0, 0, 0, 5, 1, 0);
        repeat (4) drive(1, 5, 0, 1, 0, 6, 0, 0);
        repeat (3) nop();

        // Load x7 with an immediately dependent rs2 read.
        drive(1, 0, 0, 0, 0, 7, 1, 0);
        repeat (5) drive(1, 1, 7, 0, 1, 8, 0, 0);
        repeat (3) nop();

        // Load to x0, then read x0: never pending.
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 1, 1, 1, 0, 0);
        nop();

        // Taken branch while a hazard is present, then a second taken branch.
        drive(1, 0, 0, 0, 0, 3, 1, 0);
        drive(1, 3, 0, 1, 0, 4, 0, 1);
        drive(1, 3, 0, 1, 0, 4, 0, 1);
        repeat (4) drive(1, 3, 0, 1, 0, 4, 0, 0);
        repeat (3) nop();

        // Back-to-back loads to x9.
        drive(1, 0, 0, 0, 0, 9, 1, 0);
        drive(1, 0, 0, 0, 0, 9, 1, 0);
        repeat (5) nop();

        // Reset while x7 is pending and the sequencer is flushing.
        drive(1, 0, 0, 0, 0, 7, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        nop();
        async_reset();
        drive(1, 7, 7, 1, 1, 2, 0, 0);
        repeat (2) nop();

        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) async_reset();
            drive($urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0);
        end

        @(negedge clk);
        #4;
        n_checks++;
        if (expq.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d unchecked entries, expected 0", expq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
